gain_serializer: RTL and testbench
==================================

# gain_serializer

Output-side stage of the RNN denoiser datapath. Accepts one inference result per frame as a packed bus: 22 IEEE-754 single-precision band gains plus the VAD value. Streams the result as one 32-bit word per beat over a valid/ready interface toward the downstream gain-apply/DMA logic. It is the unpacking counterpart to the feature packer that builds the 42-word feature bus ahead of the RNN core.

## Interface
Parameters:
- FLOAT, 32, width of one floating-point word in bits
- NUM_GAINS, 22, number of band gains per frame
- IDX_W, 5, width of the word index; must satisfy 2^IDX_W >= NUM_GAINS+1

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- gains_in  input  NUM_GAINS*FLOAT  packed gains; gain i = gains_in[i*FLOAT +: FLOAT]
- vad_in  input  FLOAT  voice-activity value for the same frame
- in_valid  input  1  gains_in/vad_in hold a complete frame
- in_ready  output  1  block can capture a frame
- out_data  output  FLOAT  current output word
- out_idx  output  IDX_W  index of the current word within the frame (0-based)
- out_valid  output  1  out_data/out_idx/out_last are valid
- out_ready  input  1  downstream accepts the word
- out_last  output  1  current word is the final word of the frame
- frame_cnt  output  16  count of fully transmitted frames, wraps modulo 2^16

## Operation
- Two states: IDLE and SEND.
- IDLE: in_ready=1, out_valid=0.
  - When in_valid && in_ready, the block registers gains_in and vad_in into an internal frame buffer.
  - It clears the word counter to 0 and moves to SEND.
- SEND: in_ready=0, out_valid=1.
  - out_data is the buffered word selected by the word counter.
  - out_idx equals the word counter.
- Word order with VAD enabled (see Configuration):
  - word 0 = vad
  - word k = gain k-1, for k = 1..NUM_GAINS
  - frame length L = NUM_GAINS+1 words
- Transfer: a word transfers on any cycle where out_valid && out_ready.
  - On transfer with counter < L-1, the counter increments.
  - On transfer with counter = L-1, the block increments frame_cnt and returns to IDLE.
- out_last = 1 exactly when in SEND and counter = L-1.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable. out_valid never drops before the transfer completes.
- Input changes after capture have no effect on the frame in flight, because the buffer is only written in IDLE.
- No arithmetic is performed on the floats. Words pass through bit-exact.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_last=0
  - out_data=0, out_idx=0, frame_cnt=0
  - frame buffer=0
- Latency: frame captured on edge N gives word 0 with out_valid=1 in the cycle after edge N.
- Throughput: one word per cycle when out_ready is held high.
  - With VAD: L+1 = 24 cycles per frame (L=23 words plus 1 IDLE capture cycle).
  - Without VAD: 23 cycles per frame (22 words plus 1 IDLE capture cycle).
- After the last transfer, in_ready is 1 in the next cycle. Back-to-back frames have exactly one idle output cycle between them.
- All outputs are registered or decoded only from registered state. There is no combinational path from in_valid or out_ready to any output.
- Reset asserted mid-frame: outputs return to reset values immediately, regardless of clk. The partial frame is discarded and frame_cnt is not incremented.
- frame_cnt wraps 0xFFFF -> 0x0000 without a flag.

## Configuration
- GAIN_SERIALIZER_VAD_EN
  - Defined: vad is transmitted as word 0, L = NUM_GAINS+1 = 23, and gains occupy indices 1..22.
  - Undefined: vad_in is unused and not stored, L = NUM_GAINS = 22, and gain i is at index i (out_last at index 21).
  - Handshake behaviour is otherwise identical.

## Test plan
- Reset check: hold rst_n=0 -> in_ready=1, out_valid=0, out_last=0, out_data=0, out_idx=0, frame_cnt=0. Release reset -> outputs unchanged until in_valid.
- Single frame, macro defined, out_ready=1:
  - Stimulus: vad=0x3F800000, gain i=0x40000000+i.
  - Required: words 0x3F800000, then 0x40000000..0x40000015 on 23 consecutive cycles; out_idx 0..22; out_last only at idx 22; frame_cnt=1.
- Backpressure, same stimulus: toggle out_ready 1,0,0,1 repeatedly -> word sequence identical to the previous case; data held stable during stalls; in_ready=0 throughout SEND; in_valid pulses during SEND are ignored.
- Back-to-back frames with in_valid held high and differing data -> second frame's word 0 appears exactly 1 cycle after the first frame's last transfer; frame_cnt=2.
- Reset mid-frame: assert rst_n=0 after idx 10 transfers -> out_valid=0 asynchronously and frame_cnt=0. A new frame then starts at idx 0.
- Macro undefined: same gains, vad=0xDEADBEEF -> 22 words 0x40000000..0x40000015 at idx 0..21; out_last at idx 21; 0xDEADBEEF never appears.

Source files
------------

// File: rtl/gain_serializer.sv
// Serializes one frame of band gains (optionally led by the VAD word) into 32-bit words over valid/ready.
// Optional feature macro: GAIN_SERIALIZER_VAD_EN (VAD value sent as word 0).
module gain_serializer #(
  parameter int FLOAT     = 32,
  parameter int NUM_GAINS = 22,
  parameter int IDX_W     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_GAINS*FLOAT-1:0] gains_in,
  input  logic [FLOAT-1:0]           vad_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FLOAT-1:0]           out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [15:0]                frame_cnt
);

`ifdef GAIN_SERIALIZER_VAD_EN
  localparam int L = NUM_GAINS + 1;
`else
  localparam int L = NUM_GAINS;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [FLOAT-1:0]       in_words  [L];
  logic [FLOAT-1:0]       frame_buf [L];
  logic [IDX_W-1:0]       idx_nxt;

  // Incoming frame laid out in transmit order
  always_comb begin
    for (int k = 0; k < L; k++) in_words[k] = '0;
`ifdef GAIN_SERIALIZER_VAD_EN
    in_words[0] = vad_in;
    for (int k = 0; k < NUM_GAINS; k++) in_words[k+1] = gains_in[k*FLOAT +: FLOAT];
`else
    for (int k = 0; k < NUM_GAINS; k++) in_words[k] = gains_in[k*FLOAT +: FLOAT];
`endif
  end

`ifndef GAIN_SERIALIZER_VAD_EN
  logic unused_vad;
  assign unused_vad = ^vad_in;
`endif

  assign idx_nxt = out_idx + IDX_W'(1);

  // out_idx doubles as the word counter; all outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
      for (int k = 0; k < L; k++) frame_buf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < L; k++) frame_buf[k] <= in_words[k];
            out_data  <= in_words[0];
            out_idx   <= '0;
            out_last  <= (LAST_IDX == '0);
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              in_ready  <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              out_idx  <= idx_nxt;
              out_data <= frame_buf[idx_nxt];
              out_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gain_serializer.sv
// Directed/randomized bench for gain_serializer with a queue-based reference of the frame word order.
module tb_gain_serializer;
  localparam int NG = 22;

  logic             clk;
  logic             rst_n;
  logic [NG*32-1:0] gains_in;
  logic [31:0]      vad_in;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [15:0]      frame_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  logic [31:0] g_ref [NG];
  logic [31:0] v_ref;

  gain_serializer #(.FLOAT(32), .NUM_GAINS(NG), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .gains_in(gains_in), .vad_in(vad_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_std_frame(input logic [31:0] v);
    v_ref = v;
    for (int i = 0; i < NG; i++) g_ref[i] = 32'h4000_0000 + 32'(i);
  endtask

  task automatic set_rand_frame();
    v_ref = $urandom;
    for (int i = 0; i < NG; i++) g_ref[i] = $urandom;
  endtask

  // Called at a negedge with the DUT idle; ends at the negedge after the last checked transfer.
  // bp: 0 = out_ready high, 1 = pattern 1,0,0,1, 2 = random. stop_after < 0 sends the whole frame.
  task automatic run_frame(input int bp, input bit noise, input int stop_after);
    logic [31:0] exp_q [$];
    int k, cyc, lim;
    exp_q = {};
`ifdef GAIN_SERIALIZER_VAD_EN
    exp_q.push_back(v_ref);
`endif
    for (int i = 0; i < NG; i++) exp_q.push_back(g_ref[i]);
    lim = (stop_after < 0) ? exp_q.size() : stop_after;

    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < NG; i++) gains_in[i*32 +: 32] = g_ref[i];
    vad_in   = v_ref;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;

    k = 0;
    cyc = 0;
    while (k < lim && cyc < 400) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        vad_in   = $urandom;
        for (int i = 0; i < NG; i++) gains_in[i*32 +: 32] = $urandom;
      end
      chk("send_out_valid", 32'(out_valid), 32'd1);
      chk("send_in_ready", 32'(in_ready), 32'd0);
      chk("word_data", out_data, exp_q[k]);
      chk("word_idx", 32'(out_idx), 32'(k));
      chk("word_last", 32'(out_last), 32'(k == exp_q.size() - 1));
      case (bp)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (out_ready) k++;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("words_sent", 32'(k), 32'(lim));
    if (stop_after < 0) begin
      exp_cnt++;
      chk("post_out_valid", 32'(out_valid), 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_out_last", 32'(out_last), 32'd0);
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    gains_in  = '0;
    vad_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_frame_cnt", 32'(frame_cnt), 32'd0);

    // Reference frame, no backpressure
    set_std_frame(32'h3F80_0000);
    run_frame(0, 1'b0, -1);
    @(negedge clk);

    // Same frame with 1,0,0,1 stalls and in_valid/data noise during SEND
    set_std_frame(32'h3F80_0000);
    run_frame(1, 1'b1, -1);
    @(negedge clk);

    // Back-to-back frames: the second capture happens on the very next edge
    set_rand_frame();
    run_frame(0, 1'b0, -1);
    set_rand_frame();
    run_frame(0, 1'b0, -1);

    // Random frames with random backpressure
    for (int f = 0; f < 5; f++) begin
      set_rand_frame();
      run_frame(2, 1'b1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset mid-frame after 11 transfers (idx 0..10)
    set_rand_frame();
    run_frame(0, 1'b0, 11);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_out_valid", 32'(out_valid), 32'd0);
    chk("amid_in_ready", 32'(in_ready), 32'd1);
    chk("amid_out_last", 32'(out_last), 32'd0);
    chk("amid_out_idx", 32'(out_idx), 32'd0);
    chk("amid_out_data", out_data, 32'd0);
    chk("amid_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh frame after reset, then a frame whose VAD must appear only when enabled
    set_rand_frame();
    run_frame(0, 1'b0, -1);
    @(negedge clk);
    set_std_frame(32'hDEAD_BEEF);
    run_frame(2, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
